// File: rtl/phase_sequencer.sv
// Multi-phase instruction-cycle sequencer: one-hot phase strobes with per-phase stretch,
// run/halt/single-step control, boundary stall and a completed-cycle counter.
module phase_sequencer #(
    parameter int unsigned PHASES       = 3,
    parameter int unsigned PHASE_CYCLES = 1,
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter bit          START_HALTED = 1'b0,
    localparam int unsigned PH_W        = $clog2(PHASES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_req,
    input  logic                   halt_req,
    input  logic                   step_req,
    input  logic                   stall,
    output logic [PHASES-1:0]      out,
    output logic [PH_W-1:0]        phase_idx,
    output logic                   cycle_done,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic                   halted
);

    localparam int unsigned DIV_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_HALTED = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = START_HALTED ? S_HALTED : S_RUN;

    state_t                 state, state_nxt;
    logic [PH_W-1:0]        phase, phase_nxt;
    logic [DIV_W-1:0]       div, div_nxt;
    logic                   halt_pend, halt_pend_nxt;
    logic [PHASES-1:0]      out_nxt;
    logic                   cycle_done_nxt;
    logic [COUNT_WIDTH-1:0] cycle_count_nxt;

    logic div_last;
    logic phase_last;
    logic boundary;
    logic idle_run;

    function automatic logic [PHASES-1:0] onehot(input logic [PH_W-1:0] p);
        return PHASES'(1) << p;
    endfunction

    assign div_last   = (div == DIV_W'(PHASE_CYCLES - 1));
    assign phase_last = (phase == PH_W'(PHASES - 1));
    assign boundary   = phase_last && div_last;
    // RUN straight out of reset has not yet issued phase 0; its first edge starts a cycle.
    assign idle_run   = (state == S_RUN) && (out == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RESET_STATE;
            phase       <= '0;
            div         <= '0;
            halt_pend   <= 1'b0;
            out         <= '0;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
            halted      <= START_HALTED;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            div         <= div_nxt;
            halt_pend   <= halt_pend_nxt;
            out         <= out_nxt;
            cycle_done  <= cycle_done_nxt;
            cycle_count <= cycle_count_nxt;
            halted      <= (state_nxt == S_HALTED);
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase;
        div_nxt         = div;
        halt_pend_nxt   = halt_pend;
        out_nxt         = out;
        cycle_done_nxt  = 1'b0;
        cycle_count_nxt = cycle_count;

        case (state)
            S_HALTED: begin
                out_nxt = '0;
                if (run_req || step_req) begin
                    state_nxt = run_req ? S_RUN : S_STEP;
                    phase_nxt = '0;
                    div_nxt   = '0;
                    out_nxt   = onehot(PH_W'(0));
                end
            end

            S_WAIT: begin
                out_nxt = '0;
                if (halt_req || halt_pend) begin
                    state_nxt     = S_HALTED;
                    halt_pend_nxt = 1'b0;
                end else if (!stall) begin
                    state_nxt = S_RUN;
                    phase_nxt = '0;
                    div_nxt   = '0;
                    out_nxt   = onehot(PH_W'(0));
                end
            end

            S_RUN, S_STEP: begin
                if (idle_run) begin
                    phase_nxt = '0;
                    div_nxt   = '0;
                    out_nxt   = onehot(PH_W'(0));
                    if (halt_req) begin
                        halt_pend_nxt = 1'b1;
                    end
                end else if (boundary) begin
                    cycle_done_nxt  = 1'b1;
                    cycle_count_nxt = COUNT_WIDTH'(cycle_count + COUNT_WIDTH'(1));
                    phase_nxt       = '0;
                    div_nxt         = '0;
                    if (state == S_STEP) begin
                        state_nxt = S_HALTED;
                        out_nxt   = '0;
                    end else if (halt_pend || halt_req) begin
                        state_nxt     = S_HALTED;
                        halt_pend_nxt = 1'b0;
                        out_nxt       = '0;
                    end else if (stall) begin
                        state_nxt = S_WAIT;
                        out_nxt   = '0;
                    end else begin
                        out_nxt = onehot(PH_W'(0));
                    end
                end else begin
                    if (div_last) begin
                        div_nxt   = '0;
                        phase_nxt = PH_W'(phase + PH_W'(1));
                        out_nxt   = onehot(PH_W'(phase + PH_W'(1)));
                    end else begin
                        div_nxt = DIV_W'(div + DIV_W'(1));
                    end
                    // A halt seen mid-cycle waits for the boundary; the cycle always completes.
                    if ((state == S_RUN) && halt_req) begin
                        halt_pend_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = S_HALTED;
                out_nxt   = '0;
            end
        endcase
    end

    assign phase_idx = phase;

endmodule
